// File: rtl/uart_tx_queue.sv
// Byte FIFO between the CPU UART data register and the serial emitter's valid/ready port.
// Optional CR insertion before every LF is enabled by defining UART_TXQ_CRLF_EN.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          overflow
);

  localparam logic [7:0] LF_BYTE = 8'h0A;
  localparam logic [7:0] CR_BYTE = 8'h0D;

`ifdef UART_TXQ_CRLF_EN
  typedef enum logic [1:0] {IDLE, SEND, CR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  // First byte put on the wire when byte b reaches the head of the queue.
  function automatic logic [7:0] lead_byte(input logic [7:0] b);
`ifdef UART_TXQ_CRLF_EN
    return (b == LF_BYTE) ? CR_BYTE : b;
`else
    return b;
`endif
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]   level_next;
  logic [7:0]    head_byte, next_byte, data_next;
  logic          hs, push, pop, drop;
  state_t        state, state_next;

  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign head_byte  = mem[rd_ptr];
  assign next_byte  = mem[rd_ptr_inc];
  assign hs         = tx_valid & tx_ready;
  assign pop        = hs & (state == SEND);
  assign push       = wr_valid & (~full | pop);
  assign drop       = wr_valid & full & ~pop;
  assign busy       = ~empty | ~tx_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      tx_valid <= (state_next != IDLE);
      tx_data  <= data_next;
    end
  end

  // After a pop the successor is only loaded when it was already queued;
  // a byte pushed during that same cycle is picked up by IDLE one cycle later.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (level != '0) begin
          state_next = SEND;
`ifdef UART_TXQ_CRLF_EN
          if (head_byte == LF_BYTE) state_next = CR;
`endif
        end
      end
      SEND: begin
        if (hs) begin
          if (level != (AW+1)'(1)) begin
            state_next = SEND;
`ifdef UART_TXQ_CRLF_EN
            if (next_byte == LF_BYTE) state_next = CR;
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
`ifdef UART_TXQ_CRLF_EN
      CR: if (hs) state_next = SEND;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next = tx_data;
    case (state)
      IDLE:    if (level != '0) data_next = lead_byte(head_byte);
      SEND:    if (hs && level != (AW+1)'(1)) data_next = lead_byte(next_byte);
`ifdef UART_TXQ_CRLF_EN
      CR:      if (hs) data_next = LF_BYTE;
`endif
      default: data_next = tx_data;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   level_next = level + (AW+1)'(1);
      2'b01:   level_next = level - (AW+1)'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      level <= level_next;
      full  <= (level_next == (AW+1)'(DEPTH));
      empty <= (level_next == '0);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
